// File: rtl/pport_txarb.sv
// pport_txarb: round-robin sharing of one 7-bit pport TX channel among NREQ byte streams, with (ESC,id) switch marks and ESC stuffing.
// Optional macro PPTXARB_PRIORITY_EN: requester 0 wins every arbitration and cuts other bursts short.
module pport_txarb #(
  parameter int         NREQ    = 4,
  parameter int         LGBURST = 4,
  parameter logic [6:0] ESC     = 7'h7f
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [NREQ-1:0]   i_req_stb,
  input  logic [7*NREQ-1:0] i_req_data,
  output logic [NREQ-1:0]   o_req_busy,
  output logic              o_pp_stb,
  output logic [6:0]        o_pp_data,
  input  logic              i_pp_busy,
  output logic [NREQ-1:0]   o_grant
);
  localparam int IW = $clog2(NREQ);
  localparam logic [LGBURST:0] LIM = {1'b1, {LGBURST{1'b0}}};
  typedef enum logic [2:0] {IDLE, SEL_ESC, SEL_ID, DATA, STUFF} state_t;
  state_t state_q, state_d;
  logic stb_q, stb_d, cur_valid_q, cur_valid_d;
  logic [6:0] data_q, data_d, ld_data, word;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [IW-1:0] gidx_q, gidx_d, last_q, last_d, cur_ch_q, cur_ch_d, win, idx;
  logic [LGBURST:0] cnt_q, cnt_d;
  logic load_ok, load, acc, preempt, done;
  assign load_ok = !stb_q || !i_pp_busy;
  assign word = i_req_data[7*gidx_q +: 7];
  assign acc = state_q == DATA && load_ok && i_req_stb[gidx_q];
  assign stb_d = load || (stb_q && !load_ok);
  assign data_d = load ? ld_data : data_q;
`ifdef PPTXARB_PRIORITY_EN
  assign preempt = i_req_stb[0] && gidx_q != '0;
`else
  assign preempt = 1'b0;
`endif
  // Scan from farthest to nearest so the first requester after last_q wins.
  always_comb begin
    win = '0;
    idx = '0;
    for (int i = NREQ; i >= 1; i--) begin
      idx = IW'((int'(last_q) + i) % NREQ);
      if (i_req_stb[idx]) win = idx;
    end
`ifdef PPTXARB_PRIORITY_EN
    if (i_req_stb[0]) win = '0;
`endif
  end
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    gidx_d = gidx_q;
    last_d = last_q;
    cur_ch_d = cur_ch_q;
    cur_valid_d = cur_valid_q;
    cnt_d = cnt_q;
    load = 1'b0;
    ld_data = ESC;
    done = 1'b0;
    o_req_busy = '1;
    case (state_q)
      IDLE: if (|i_req_stb) begin
        grant_d = '0;
        grant_d[win] = 1'b1;
        gidx_d = win;
        cnt_d = '0;
        state_d = (cur_valid_q && cur_ch_q == win) ? DATA : SEL_ESC;
      end
      SEL_ESC: if (load_ok) begin
        load = 1'b1;
        state_d = SEL_ID;
      end
      SEL_ID: if (load_ok) begin
        load = 1'b1;
        ld_data = 7'(gidx_q);
        cur_ch_d = gidx_q;
        cur_valid_d = 1'b1;
        state_d = DATA;
      end
      DATA: begin
        o_req_busy[gidx_q] = !load_ok;
        if (acc) begin
          load = 1'b1;
          ld_data = word;
          cnt_d = cnt_q + 1'b1;
          if (word == ESC) state_d = STUFF;
          else done = cnt_d == LIM || preempt;
        end else done = load_ok;
      end
      STUFF: if (load_ok) begin
        load = 1'b1;
        done = cnt_q == LIM || !i_req_stb[gidx_q] || preempt;
        state_d = DATA;
      end
      default: state_d = IDLE;
    endcase
    if (done) begin
      state_d = IDLE;
      last_d = gidx_q;
      grant_d = '0;
    end
  end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      state_q <= IDLE;
      stb_q <= 1'b0;
      data_q <= '0;
      grant_q <= '0;
      gidx_q <= '0;
      last_q <= '0;
      cur_ch_q <= '0;
      cur_valid_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      stb_q <= stb_d;
      data_q <= data_d;
      grant_q <= grant_d;
      gidx_q <= gidx_d;
      last_q <= last_d;
      cur_ch_q <= cur_ch_d;
      cur_valid_q <= cur_valid_d;
      cnt_q <= cnt_d;
    end
  assign o_pp_stb = stb_q;
  assign o_pp_data = data_q;
  assign o_grant = grant_q;
endmodule

// File: tb/tb_pport_txarb.sv
// tb_pport_txarb: directed bench for pport_txarb with queue-fed requesters and an output word recorder.
module tb_pport_txarb;
  localparam int NREQ = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [NREQ-1:0] req_stb = '0;
  logic [7*NREQ-1:0] req_data = '0;
  logic [NREQ-1:0] req_busy, grant, acc;
  logic pp_stb, pp_busy = 1'b0;
  logic [6:0] pp_data;
  int checks = 0;
  int fails = 0;
  logic [6:0] srcq[NREQ][$];
  logic [6:0] outq[$];
  logic [NREQ-1:0] gq[$];
  logic [6:0] exp[$];
  always #5 clk = ~clk;
  pport_txarb #(.NREQ(NREQ), .LGBURST(4), .ESC(7'h7f)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_req_stb(req_stb), .i_req_data(req_data),
    .o_req_busy(req_busy), .o_pp_stb(pp_stb), .o_pp_data(pp_data),
    .i_pp_busy(pp_busy), .o_grant(grant)
  );
  // Requesters present the head of their queue and pop it once accepted.
  initial forever begin
    @(negedge clk);
    acc = req_stb & ~req_busy;
    @(posedge clk);
    #1;
    for (int k = 0; k < NREQ; k++) begin
      if (acc[k] && srcq[k].size() > 0) void'(srcq[k].pop_front());
      req_stb[k] = srcq[k].size() > 0;
      req_data[7*k +: 7] = srcq[k].size() > 0 ? srcq[k][0] : 7'h0;
    end
  end
  always @(negedge clk)
    if (rst_n && pp_stb && !pp_busy) begin
      outq.push_back(pp_data);
      gq.push_back(grant);
    end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  task automatic wait_out(input int n);
    for (int b = 0; b < 400 && outq.size() < n; b++) begin
      @(negedge clk);
      #1;
    end
    repeat (6) @(negedge clk);
    #1;
  endtask
  task automatic test_reset;
    #1 rst_n = 1'b0;
    #11;
    checks++; if (pp_stb !== 1'b0) begin fails++; $display("FAIL reset_stb: got %b want 0", pp_stb); end
    checks++; if (pp_data !== 7'h00) begin fails++; $display("FAIL reset_data: got %h want 00", pp_data); end
    checks++; if (grant !== 4'b0000) begin fails++; $display("FAIL reset_grant: got %b want 0000", grant); end
    checks++; if (req_busy !== 4'b1111) begin fails++; $display("FAIL reset_busy: got %b want 1111", req_busy); end
    @(posedge clk); #2; rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (pp_stb !== 1'b0 || grant !== 4'b0000) begin fails++; $display("FAIL idle_after_reset: got stb %b grant %b want 0 0000", pp_stb, grant); end
  endtask
  task automatic test_basic;
    outq.delete(); gq.delete();
    @(posedge clk); #2;
    srcq[1].push_back(7'h41); srcq[1].push_back(7'h42);
    wait_out(4);
    exp = '{7'h7f, 7'h01, 7'h41, 7'h42};
    checks++; if (outq.size() != 4) begin fails++; $display("FAIL basic_len: got %0d want 4", outq.size()); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (i >= outq.size() || outq[i] !== exp[i]) begin fails++; $display("FAIL basic_word[%0d]: got %h want %h", i, i < outq.size() ? outq[i] : 7'h0, exp[i]); end
      checks++; if (i >= gq.size() || gq[i] !== 4'b0010) begin fails++; $display("FAIL basic_grant[%0d]: got %b want 0010", i, i < gq.size() ? gq[i] : 4'h0); end
    end
    checks++; if (grant !== 4'b0000) begin fails++; $display("FAIL basic_grant_idle: got %b want 0000", grant); end
  endtask
  task automatic test_stuff;
    bit seen = 1'b0;
    outq.delete(); gq.delete();
    @(posedge clk); #2;
    srcq[2].push_back(7'h7f); srcq[2].push_back(7'h55);
    for (int b = 0; b < 30 && !seen; b++) begin
      @(negedge clk); #1;
      if (outq.size() == 3) begin
        seen = 1'b1;
        checks++; if (req_busy[2] !== 1'b1) begin fails++; $display("FAIL stuff_busy: got %b want 1", req_busy[2]); end
      end
    end
    checks++; if (!seen) begin fails++; $display("FAIL stuff_timeout: got %0d words want 3", outq.size()); end
    wait_out(5);
    exp = '{7'h7f, 7'h02, 7'h7f, 7'h7f, 7'h55};
    checks++; if (outq.size() != 5) begin fails++; $display("FAIL stuff_len: got %0d want 5", outq.size()); end
    for (int i = 0; i < 5; i++) begin
      checks++; if (i >= outq.size() || outq[i] !== exp[i]) begin fails++; $display("FAIL stuff_word[%0d]: got %h want %h", i, i < outq.size() ? outq[i] : 7'h0, exp[i]); end
    end
  endtask
  task automatic test_rr;
    outq.delete(); gq.delete(); exp.delete();
    @(posedge clk); #2;
    for (int i = 0; i < 20; i++) srcq[0].push_back(7'(16 + i));
    @(posedge clk); #2;
    for (int i = 0; i < 20; i++) srcq[3].push_back(7'(48 + i));
`ifdef PPTXARB_PRIORITY_EN
    exp.push_back(7'h7f); exp.push_back(7'h00);
    for (int i = 0; i < 20; i++) exp.push_back(7'(16 + i));
    exp.push_back(7'h7f); exp.push_back(7'h03);
    for (int i = 0; i < 20; i++) exp.push_back(7'(48 + i));
`else
    exp.push_back(7'h7f); exp.push_back(7'h00);
    for (int i = 0; i < 16; i++) exp.push_back(7'(16 + i));
    exp.push_back(7'h7f); exp.push_back(7'h03);
    for (int i = 0; i < 16; i++) exp.push_back(7'(48 + i));
    exp.push_back(7'h7f); exp.push_back(7'h00);
    for (int i = 16; i < 20; i++) exp.push_back(7'(16 + i));
    exp.push_back(7'h7f); exp.push_back(7'h03);
    for (int i = 16; i < 20; i++) exp.push_back(7'(48 + i));
`endif
    wait_out(exp.size());
    checks++; if (outq.size() != exp.size()) begin fails++; $display("FAIL rr_len: got %0d want %0d", outq.size(), exp.size()); end
    for (int i = 0; i < exp.size(); i++) begin
      checks++; if (i >= outq.size() || outq[i] !== exp[i]) begin fails++; $display("FAIL rr_word[%0d]: got %h want %h", i, i < outq.size() ? outq[i] : 7'h0, exp[i]); end
    end
  endtask
  task automatic test_stall;
    outq.delete(); gq.delete(); exp.delete();
    @(posedge clk); #2;
    for (int i = 0; i < 8; i++) srcq[1].push_back(7'(96 + i));
    for (int b = 0; b < 50 && outq.size() < 4; b++) begin @(negedge clk); #1; end
    @(posedge clk); #2; pp_busy = 1'b1;
    repeat (5) begin
      @(negedge clk);
      checks++; if (pp_stb !== 1'b1 || pp_data !== 7'h62) begin fails++; $display("FAIL stall_hold: got stb %b data %h want 1 62", pp_stb, pp_data); end
    end
    @(posedge clk); #2; pp_busy = 1'b0;
    exp.push_back(7'h7f); exp.push_back(7'h01);
    for (int i = 0; i < 8; i++) exp.push_back(7'(96 + i));
    wait_out(10);
    checks++; if (outq.size() != 10) begin fails++; $display("FAIL stall_len: got %0d want 10", outq.size()); end
    for (int i = 0; i < 10; i++) begin
      checks++; if (i >= outq.size() || outq[i] !== exp[i]) begin fails++; $display("FAIL stall_word[%0d]: got %h want %h", i, i < outq.size() ? outq[i] : 7'h0, exp[i]); end
    end
  endtask
  task automatic test_reset_mid;
    outq.delete(); gq.delete();
    @(posedge clk); #2;
    for (int i = 0; i < 10; i++) srcq[3].push_back(7'(32 + i));
    for (int b = 0; b < 50 && outq.size() < 4; b++) begin @(negedge clk); #1; end
    rst_n = 1'b0;
    srcq[3].delete();
    #1;
    checks++; if (pp_stb !== 1'b0 || pp_data !== 7'h00) begin fails++; $display("FAIL midreset_out: got stb %b data %h want 0 00", pp_stb, pp_data); end
    checks++; if (grant !== 4'b0000 || req_busy !== 4'b1111) begin fails++; $display("FAIL midreset_ctl: got grant %b busy %b want 0000 1111", grant, req_busy); end
    @(posedge clk); #2; rst_n = 1'b1;
    repeat (4) @(negedge clk);
    checks++; if (pp_stb !== 1'b0 || grant !== 4'b0000) begin fails++; $display("FAIL midreset_idle: got stb %b grant %b want 0 0000", pp_stb, grant); end
  endtask
  task automatic test_long;
    outq.delete(); gq.delete(); exp.delete();
    @(posedge clk); #2;
    for (int i = 0; i < 40; i++) srcq[1].push_back(7'(i));
    exp.push_back(7'h7f); exp.push_back(7'h01);
    for (int i = 0; i < 40; i++) exp.push_back(7'(i));
    wait_out(42);
    checks++; if (outq.size() != 42) begin fails++; $display("FAIL long_len: got %0d want 42", outq.size()); end
    for (int i = 0; i < 42; i++) begin
      checks++; if (i >= outq.size() || outq[i] !== exp[i]) begin fails++; $display("FAIL long_word[%0d]: got %h want %h", i, i < outq.size() ? outq[i] : 7'h0, exp[i]); end
    end
  endtask
`ifdef PPTXARB_PRIORITY_EN
  task automatic test_priority;
    outq.delete(); gq.delete(); exp.delete();
    @(posedge clk); #2;
    for (int i = 0; i < 10; i++) srcq[2].push_back(7'(64 + i));
    for (int b = 0; b < 50 && outq.size() < 5; b++) begin @(negedge clk); #1; end
    srcq[0].push_back(7'h50); srcq[0].push_back(7'h51);
    exp = '{7'h7f, 7'h02, 7'h40, 7'h41, 7'h42, 7'h43, 7'h44, 7'h7f, 7'h00, 7'h50, 7'h51,
            7'h7f, 7'h02, 7'h45, 7'h46, 7'h47, 7'h48, 7'h49};
    wait_out(18);
    checks++; if (outq.size() != 18) begin fails++; $display("FAIL prio_len: got %0d want 18", outq.size()); end
    for (int i = 0; i < 18; i++) begin
      checks++; if (i >= outq.size() || outq[i] !== exp[i]) begin fails++; $display("FAIL prio_word[%0d]: got %h want %h", i, i < outq.size() ? outq[i] : 7'h0, exp[i]); end
    end
  endtask
`endif
  initial begin
    test_reset();
    test_basic();
    test_stuff();
    test_rr();
    test_stall();
    test_reset_mid();
    test_long();
`ifdef PPTXARB_PRIORITY_EN
    test_priority();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/pport_txarb.md
Name: pport_txarb

Overview:
- Shares the single 7-bit parallel-port transmit channel (stb/busy handshake into the pport TX FIFO input) among NREQ independent byte-stream requesters.
- Round-robin arbitration with bounded bursts; every channel switch is marked in-band by a 2-word select sequence (ESC, id).
- Literal ESC data words are byte-stuffed, so the far end can demultiplex the streams.
- Sits between the on-chip producers (console, debug bus, etc.) and the wbpport-style TX path.

Parameters:
- NREQ, 4, number of requesters; legal range 2..8.
- LGBURST, 4, log2 of the maximum data words per grant before re-arbitration.
- ESC, 7'h7f, escape code. Select id words are 7'h00..7'h07 and never equal ESC.

Ports:
- i_clk, input, 1, system clock.
- i_rst_n, input, 1, asynchronous active-low reset.
- i_req_stb, input, NREQ, per-requester data valid.
- i_req_data, input, 7*NREQ, requester k data in bits [7k+6:7k].
- o_req_busy, output, NREQ, per-requester stall. Word k is accepted when i_req_stb[k] && !o_req_busy[k].
- o_pp_stb, output, 1, output word valid.
- o_pp_data, output, 7, output word.
- i_pp_busy, input, 1, downstream stall. A word is transferred when o_pp_stb && !i_pp_busy.
- o_grant, output, NREQ, one-hot current owner; zero when idle.

Behaviour:
- Reset (async assert, sync release):
  - o_pp_stb=0, o_pp_data=0, o_grant=0, o_req_busy=all ones, state=IDLE.
  - cur_valid=0, so the first grant after reset always emits a select sequence.
  - Burst counter=0, RR pointer=0.
- Output register: load_ok = !o_pp_stb || !i_pp_busy. When load_ok and nothing is loaded, o_pp_stb drops to 0. o_pp_data is held stable while o_pp_stb && i_pp_busy.
- IDLE:
  - If any i_req_stb is set, pick the first requester at or after (last+1) mod NREQ, scanning upward with wrap.
  - Set o_grant and clear the burst counter.
  - Next state: DATA if cur_valid && winner==cur_ch, else SEL_ESC.
  - Arbitration costs exactly 1 cycle.
- SEL_ESC: when load_ok, load ESC; go to SEL_ID.
- SEL_ID: when load_ok, load {4'b0, id}; set cur_ch=id and cur_valid=1; go to DATA.
- DATA:
  - o_req_busy[g] = !load_ok. All other requesters have busy=1.
  - On accept of word w: load w and increment the burst counter.
  - If w==ESC, go to STUFF.
  - If the counter reaches 2^LGBURST, go to IDLE (last=g).
  - If load_ok && !i_req_stb[g], go to IDLE with no load (last=g).
- STUFF: when load_ok, load ESC (second copy). Then go to IDLE if the burst limit was reached or stb is low, else DATA.
- Latency: a requester word accepted in cycle n appears on o_pp_data in cycle n+1. Zero-bubble streaming within a burst when i_pp_busy=0.
- Simultaneous requests: only o_grant's owner can be accepted. Non-granted requesters wait; no starvation beyond (NREQ-1) bursts.
- A requester must hold stb/data stable until accepted. Dropping stb mid-burst releases the grant.
- If the same requester wins again after its own burst and no other switch intervened, no select is re-sent.
- Reset mid-operation: the output word and any pending stuff/select are discarded; cur_valid=0.
- Burst counter width is LGBURST+1; it never wraps because it is cleared on every grant.

Optional Feature:
- Macro PPTXARB_PRIORITY_EN.
- When defined:
  - Requester 0 is high priority: IDLE always picks requester 0 if i_req_stb[0].
  - While another requester owns the channel and i_req_stb[0] is asserted, that burst ends after the current word (and any pending STUFF completes first).
- When undefined: pure round-robin as above.

Test Plan:
- Reset, then req1 sends 7'h41, 7'h42 with i_pp_busy=0 -> output 7f,01,41,42; o_grant=0010 during the burst, then 0000.
- req2 sends 7'h7f -> output 7f,02,7f,7f; o_req_busy[2]=1 during the stuff cycle.
- req0 and req3 both continuously send 20 words, LGBURST=4 -> output 7f,00,16 words of req0, 7f,03,16 words of req3, 7f,00,4 words of req0, 7f,03,4 words of req3.
- i_pp_busy held 1 for 5 cycles mid-burst -> o_pp_data stable, o_pp_stb=1, no words lost or duplicated; the stream resumes in order.
- Only req1 requests 40 words -> select sent once at the start only; bursts of 16, 16, 8 with no repeated 7f,01.
- PPTXARB_PRIORITY_EN: req2 mid-burst, req0 asserts -> at most one more req2 word, then 7f,00 and the req0 data.
